// File: rtl/iccm_loader_pkg.sv
// Shared types and default constants for the ICCM boot loader.
package iccm_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } loader_state_e;

    // Word value that terminates an image; it is never written to memory.
    localparam logic [31:0] DefaultEndWord   = 32'h0000_0FFF;

    // Idle cycles tolerated between bytes of a partially received word.
    localparam logic [19:0] DefaultTimeoutCy = 20'd1_000_000;

endpackage

// File: rtl/iccm_word_packer.sv
// Little-endian byte-to-word packer: collects three bytes in a holding
// register and presents the full word combinationally with the fourth.
module iccm_word_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic [1:0]  byte_cnt_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] data_q, data_d;

    // Insert the incoming byte at the lane selected by the byte counter.
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clear_i) begin
            cnt_d  = 2'd0;
            data_d = 24'd0;
        end else if (byte_valid_i) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    data_d[7:0]   = byte_i;
                2'd1:    data_d[15:8]  = byte_i;
                2'd2:    data_d[23:16] = byte_i;
                default: data_d        = 24'd0;
            endcase
        end
    end

    // Holding register and byte counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 2'd0;
            data_q <= 24'd0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign word_o       = {byte_i, data_q};
    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
    assign byte_cnt_o   = cnt_q;

endmodule

// File: rtl/iccm_loader.sv
// Boot loader: packs a serial byte stream into ICCM word writes and holds
// the core in program reset until the image is terminated or memory fills.
module iccm_loader
    import iccm_loader_pkg::*;
#(
    parameter int unsigned Aw        = 12,
    parameter logic [31:0] EndWord   = DefaultEndWord,
    parameter logic [19:0] TimeoutCy = DefaultTimeoutCy
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [7:0]    rx_byte_i,
    input  logic          rx_valid_i,
    output logic [Aw-1:0] iccm_ctrl_addr_o,
    output logic [31:0]   iccm_ctrl_wdata_o,
    output logic          iccm_ctrl_we_o,
    output logic          prog_rst_no,
    output logic          done_o,
    output logic          err_o,
    output logic [Aw:0]   word_cnt_o
);

    localparam logic [Aw:0] LastIdx = {1'b0, {Aw{1'b1}}};
    localparam logic [Aw:0] CntOne  = {{Aw{1'b0}}, 1'b1};

    loader_state_e state_q, state_d;
    logic [Aw:0]   cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [Aw-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [19:0]   to_q, to_d;
    logic          done_q;

    logic          accept;
    logic          clear;
    logic          timeoutHit;
    logic [31:0]   word;
    logic          wordValid;
    logic [1:0]    byteCnt;

    // Bytes are only taken while idle (first byte of the image) or loading.
    assign accept = rx_valid_i && ((state_q == IDLE) || (state_q == LOAD));

    // A mid-word stall of TimeoutCy consecutive idle cycles aborts the load.
    assign timeoutHit = (state_q == LOAD) && (byteCnt != 2'd0) && !rx_valid_i &&
                        (to_q == TimeoutCy - 20'd1);

    // The partial word is thrown away when the load aborts.
    assign clear = timeoutHit;

    iccm_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear),
        .byte_valid_i (accept),
        .byte_i       (rx_byte_i),
        .word_o       (word),
        .word_valid_o (wordValid),
        .byte_cnt_o   (byteCnt)
    );

    // Next-state logic: FSM, write issue, word index and idle-cycle counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        to_d    = 20'd0;
        case (state_q)
            IDLE: begin
                if (rx_valid_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (wordValid) begin
                    if (word == EndWord) begin
                        state_d = DONE;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[Aw-1:0];
                        wdata_d = word;
                        cnt_d   = cnt_q + CntOne;
                        if (cnt_q == LastIdx) begin
                            state_d = DONE;
                        end
                    end
                end else if (timeoutHit) begin
                    state_d = ERR;
                end else if ((byteCnt != 2'd0) && !rx_valid_i) begin
                    to_d = to_q + 20'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // State, counters and registered write-port outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            to_q    <= 20'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            to_q    <= to_d;
            done_q  <= (state_q == DONE);
        end
    end

    assign iccm_ctrl_addr_o  = addr_q;
    assign iccm_ctrl_wdata_o = wdata_q;
    assign iccm_ctrl_we_o    = we_q;
    assign word_cnt_o        = cnt_q;
    assign done_o            = done_q;
    assign prog_rst_no       = done_q;
    assign err_o             = (state_q == ERR);

endmodule

// File: tb/tb_iccm_loader.sv
// Self-checking bench for iccm_loader with a small memory and short timeout.
module tb_iccm_loader;

    localparam int          Aw        = 2;
    localparam int          Depth     = 1 << Aw;
    localparam logic [31:0] EndWord   = 32'h0000_0FFF;
    localparam int          TimeoutCy = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [7:0]    rx_byte_i = 8'd0;
    logic          rx_valid_i = 1'b0;
    logic [Aw-1:0] iccm_ctrl_addr_o;
    logic [31:0]   iccm_ctrl_wdata_o;
    logic          iccm_ctrl_we_o;
    logic          prog_rst_no;
    logic          done_o;
    logic          err_o;
    logic [Aw:0]   word_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    logic [Aw+31:0] obsQ[$];
    logic [Aw+31:0] expQ[$];
    logic [31:0]    stimWords[$];
    logic           expDone;
    int             expCnt;
    logic           prevWe = 1'b0;

    iccm_loader #(
        .Aw        (Aw),
        .EndWord   (EndWord),
        .TimeoutCy (20'(TimeoutCy))
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .rx_byte_i         (rx_byte_i),
        .rx_valid_i        (rx_valid_i),
        .iccm_ctrl_addr_o  (iccm_ctrl_addr_o),
        .iccm_ctrl_wdata_o (iccm_ctrl_wdata_o),
        .iccm_ctrl_we_o    (iccm_ctrl_we_o),
        .prog_rst_no       (prog_rst_no),
        .done_o            (done_o),
        .err_o             (err_o),
        .word_cnt_o        (word_cnt_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Log every write strobe and flag a strobe that directly follows another.
    always @(negedge clk_i) begin
        if (iccm_ctrl_we_o) begin
            obsQ.push_back({iccm_ctrl_addr_o, iccm_ctrl_wdata_o});
            checkOutput("we_single_cycle", 64'(prevWe), 64'd0);
        end
        prevWe = iccm_ctrl_we_o;
    end

    task automatic sendByte(input logic [7:0] b, input int idleAfter);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'($urandom);
        repeat (idleAfter) @(negedge clk_i);
    endtask

    task automatic applyReset();
        rx_valid_i = 1'b0;
        rst_ni     = 1'b0;
        repeat (2) @(negedge clk_i);
        obsQ.delete();
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // Streams stimWords little-endian with random idle gaps.
    task automatic applyStimulus(input int maxByteGap, input int minWordGap,
                                 input int maxWordGap);
        logic [31:0] wd;
        int gap;
        foreach (stimWords[w]) begin
            wd = stimWords[w];
            for (int k = 0; k < 4; k++) begin
                if (k == 3) gap = int'($urandom_range(maxWordGap, minWordGap));
                else        gap = int'($urandom_range(maxByteGap, 0));
                sendByte(wd[8*k +: 8], gap);
            end
        end
    endtask

    // Reference: words land at consecutive addresses until the terminator
    // or until every memory location has been written.
    task automatic buildModel();
        int  written = 0;
        bit  stopped = 1'b0;
        expQ.delete();
        foreach (stimWords[w]) begin
            if (!stopped) begin
                if (stimWords[w] == EndWord) begin
                    stopped = 1'b1;
                end else begin
                    expQ.push_back({Aw'(written), stimWords[w]});
                    written++;
                    if (written == Depth) stopped = 1'b1;
                end
            end
        end
        expDone = stopped;
        expCnt  = written;
    endtask

    task automatic compareResults(input string tag);
        checkOutput({tag, "_nwrites"}, 64'(obsQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
            checkOutput({tag, "_write"}, 64'(obsQ[i]), 64'(expQ[i]));
        checkOutput({tag, "_done"}, 64'(done_o), 64'(expDone));
        checkOutput({tag, "_prog_rst_n"}, 64'(prog_rst_no), 64'(expDone));
        checkOutput({tag, "_err"}, 64'(err_o), 64'd0);
        checkOutput({tag, "_word_cnt"}, 64'(word_cnt_o), 64'(expCnt));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_addr"}, 64'(iccm_ctrl_addr_o), 64'd0);
        checkOutput({tag, "_wdata"}, 64'(iccm_ctrl_wdata_o), 64'd0);
        checkOutput({tag, "_we"}, 64'(iccm_ctrl_we_o), 64'd0);
        checkOutput({tag, "_prog_rst_n"}, 64'(prog_rst_no), 64'd0);
        checkOutput({tag, "_done"}, 64'(done_o), 64'd0);
        checkOutput({tag, "_err"}, 64'(err_o), 64'd0);
        checkOutput({tag, "_word_cnt"}, 64'(word_cnt_o), 64'd0);
    endtask

    // Directed and randomized scenarios run in sequence.
    initial begin
        int nWords;
        int termPos;

        repeat (2) @(negedge clk_i);
        checkResetValues("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Two words then terminator, back to back.
        stimWords = '{32'h1234_5678, 32'hDEAD_BEEF, EndWord};
        buildModel();
        foreach (stimWords[w])
            for (int k = 0; k < 4; k++) sendByte(stimWords[w][8*k +: 8], 0);
        checkOutput("release_not_yet", 64'(prog_rst_no), 64'd0);
        @(negedge clk_i);
        checkOutput("release_now", 64'(prog_rst_no), 64'd1);
        repeat (3) @(negedge clk_i);
        compareResults("basic");

        // Write latency and back-to-back packing.
        applyReset();
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        sendByte(8'h33, 0);
        checkOutput("lat_we_before", 64'(iccm_ctrl_we_o), 64'd0);
        sendByte(8'h44, 0);
        checkOutput("lat_we_n1", 64'(iccm_ctrl_we_o), 64'd1);
        checkOutput("lat_wdata0", 64'(iccm_ctrl_wdata_o), 64'h4433_2211);
        checkOutput("lat_addr0", 64'(iccm_ctrl_addr_o), 64'd0);
        sendByte(8'h55, 0);
        checkOutput("lat_we_n2", 64'(iccm_ctrl_we_o), 64'd0);
        sendByte(8'h66, 0);
        sendByte(8'h77, 0);
        sendByte(8'h88, 0);
        checkOutput("lat_we_w1", 64'(iccm_ctrl_we_o), 64'd1);
        checkOutput("lat_wdata1", 64'(iccm_ctrl_wdata_o), 64'h8877_6655);
        checkOutput("lat_addr1", 64'(iccm_ctrl_addr_o), 64'd1);
        @(negedge clk_i);
        checkOutput("lat_wdata_hold", 64'(iccm_ctrl_wdata_o), 64'h8877_6655);
        checkOutput("lat_word_cnt", 64'(word_cnt_o), 64'd2);

        // Memory fills: five words, no terminator.
        applyReset();
        stimWords.delete();
        for (int i = 0; i < 5; i++) stimWords.push_back(32'($urandom) | 32'h0001_0000);
        buildModel();
        applyStimulus(2, 0, 3);
        repeat (5) @(negedge clk_i);
        compareResults("full");

        // Mid-word timeout.
        applyReset();
        sendByte(8'hAA, 0);
        sendByte(8'hBB, 0);
        repeat (TimeoutCy - 1) @(negedge clk_i);
        checkOutput("to_err_early", 64'(err_o), 64'd0);
        repeat (3) @(negedge clk_i);
        checkOutput("to_err", 64'(err_o), 64'd1);
        checkOutput("to_prog_rst_n", 64'(prog_rst_no), 64'd0);
        for (int k = 0; k < 6; k++) sendByte(8'(k), 0);
        repeat (4) @(negedge clk_i);
        checkOutput("to_no_writes", 64'(obsQ.size()), 64'd0);
        checkOutput("to_err_sticky", 64'(err_o), 64'd1);
        checkOutput("to_done", 64'(done_o), 64'd0);

        // Long idle between whole words is not a timeout.
        applyReset();
        stimWords = '{32'hCAFE_F00D, 32'h0BAD_C0DE, EndWord};
        buildModel();
        applyStimulus(1, TimeoutCy + 4, TimeoutCy + 4);
        repeat (3) @(negedge clk_i);
        compareResults("idle_between");

        // Reset in the middle of the third word, then a fresh load.
        applyReset();
        stimWords = '{32'h0101_0101, 32'h0202_0202};
        applyStimulus(1, 0, 2);
        sendByte(8'h33, 0);
        sendByte(8'h44, 0);
        rst_ni = 1'b0;
        #1;
        checkResetValues("midreset");
        applyReset();
        stimWords = '{32'h5555_AAAA, EndWord};
        buildModel();
        applyStimulus(2, 0, 2);
        repeat (4) @(negedge clk_i);
        compareResults("reload");

        // Randomized streams, sometimes terminated early.
        for (int iter = 0; iter < 8; iter++) begin
            applyReset();
            stimWords.delete();
            nWords = int'($urandom_range(6, 1));
            for (int i = 0; i < nWords; i++) stimWords.push_back(32'($urandom));
            termPos = int'($urandom_range(nWords, 0));
            if (termPos < nWords) stimWords[termPos] = EndWord;
            buildModel();
            applyStimulus(4, 0, 24);
            repeat (5) @(negedge clk_i);
            compareResults("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
